ring_monitor: RTL and testbench
===============================

Name: ring_monitor

Overview:
- Downstream checker for the 4-bit rotating shift register; samples its parallel output `q` every cycle the register shifts.
- Verifies the word is a legal one-hot pattern advancing by one rotation step (new = {prev[W-2:0], prev[W-1]}).
- Declares lock after a run of good steps and counts full revolutions.
- Flags and counts faults, e.g. a stuck-at-zero ring, corrupted bits, or skipped steps.

Parameters:
WIDTH, 4, width of monitored ring word (>=2)
LOCK_COUNT, 4, consecutive good rotation steps required to enter LOCKED (>=1)
REV_W, 8, width of revolution counter
ERR_W, 4, width of fault counter

Ports:
clk  input  1  rising-edge clock, shared with ring register
rst  input  1  synchronous active-high reset
q_in  input  WIDTH  parallel output of ring register
en  input  1  sample strobe; high in cycles where ring register shifted
clr_err  input  1  acknowledge/clear fault, one-cycle pulse
locked  output  1  high while in LOCKED
error  output  1  sticky fault flag, high while in FAULT
rev_tick  output  1  one-cycle pulse per completed revolution
rev_count  output  REV_W  completed revolutions since lock/reset, wraps modulo 2^REV_W
err_count  output  ERR_W  faults since reset, saturates at all-ones

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs registered and cleared by `rst` on the next rising edge. State=EMPTY, prev=0, good_cnt=0, locked=0, error=0, rev_tick=0, rev_count=0, err_count=0. `rst` overrides every other input, in any state, mid-operation.
- Latency: outputs reflect a sample one cycle after the edge where en=1 captured q_in.
- Definitions:
  - onehot = exactly one bit of q_in set.
  - step_ok = onehot AND q_in == rotl(prev), where rotl(prev) = {prev[W-2:0], prev[W-1]}.
- en=0: state, prev, counters and flags hold; rev_tick=0; q_in ignored.
- EMPTY (no reference sample), on en:
  - onehot: prev<=q_in, good_cnt<=0, go to ACQUIRE.
  - otherwise (including all-zero): stay. No fault is raised, so a ring still sitting at its reset value is not an error before lock.
- ACQUIRE, on en:
  - prev<=q_in.
  - step_ok: good_cnt++. If good_cnt+1==LOCK_COUNT, go to LOCKED (locked=1 next cycle) and clear rev_count to 0.
  - onehot but not step_ok: good_cnt<=0, stay in ACQUIRE (re-seed).
  - not onehot: go to EMPTY.
- LOCKED, on en:
  - step_ok: prev<=q_in. If q_in[0]==1 (wrap from MSB), rev_tick=1 for one cycle and rev_count increments, wrapping modulo 2^REV_W.
  - otherwise: go to FAULT. locked=0, error=1, err_count increments unless already all-ones. prev not updated.
  - The locking sample itself never produces rev_tick.
- FAULT:
  - en ignored.
  - clr_err=1: go to EMPTY, error=0, good_cnt=0. err_count and rev_count retained.
  - clr_err outside FAULT: no effect.
  - clr_err and en in the same cycle in FAULT: clear wins, sample discarded (next valid sample starts EMPTY).
- Invariants: locked and error never high together. rev_tick only while locked=1.
- Implementation: good_cnt width = clog2(LOCK_COUNT+1). States are one-hot or binary encoded (implementer's choice). No combinational path from inputs to outputs.

Test Plan:
1. Stuck ring: rst, then q_in=0000, en=1 for 10 cycles -> locked=0, error=0, err_count=0 throughout.
2. Lock and revolution: en=1, q_in sequence 0001,0010,0100,1000,0001 -> locked=1 the cycle after the 5th sample, rev_tick=0. Continue 0010,0100,1000,0001 -> exactly one rev_tick pulse after final 0001, rev_count=1. Four more rotations -> rev_count=2.
3. Fault and clear: locked, inject 0011 -> next cycle error=1, locked=0, err_count=1. Hold 5 cycles with en=1 and valid rotations -> unchanged. clr_err pulse -> error=0, state EMPTY, err_count still 1. Relock needs a further 5 samples.
4. Skipped step in ACQUIRE: 0001,0010,1000,0001,0010,0100,1000 -> locked stays 0 until after 1000 (4 good steps counted from re-seed at 1000). Also clr_err and en together in FAULT -> error=0, sample ignored.
5. Enable gating: locked, en=0 for 6 cycles while q_in toggles random values -> no fault, no rev_tick, counts unchanged. Resume en=1 with correct next rotation -> stays locked.
6. Boundaries: REV_W=2 -> after 4 revolutions rev_count=0 (wrap). ERR_W=2 with 5 fault/clear cycles -> err_count=3 (saturated). rst while locked with rev_count=3 -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/ring_monitor.sv
// ring_monitor: checks that a rotating one-hot ring register advances by exactly
// one rotl step per shift, declares lock after a run of good steps, counts full
// revolutions while locked, and latches a sticky fault until acknowledged.
module ring_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int REV_W      = 8,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             en,
    input  logic             clr_err,
    output logic             locked,
    output logic             error,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_count,
    output logic [ERR_W-1:0] err_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_cnt;

    logic             onehot;
    logic             step_ok;
    logic [WIDTH-1:0] rotl_prev;

    // Classify the incoming word against the stored reference sample.
    always_comb begin
        rotl_prev = {prev[WIDTH-2:0], prev[WIDTH-1]};
        onehot    = (q_in != '0) && ((q_in & (q_in - WIDTH'(1))) == '0);
        step_ok   = onehot && (q_in == rotl_prev);
    end

    // Monitor FSM with all outputs registered; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            prev      <= '0;
            good_cnt  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            rev_tick  <= 1'b0;
            rev_count <= '0;
            err_count <= '0;
        end else begin
            rev_tick <= 1'b0;
            case (state)
                EMPTY: begin
                    // A zero (reset-valued) ring is tolerated here: no reference yet.
                    if (en && onehot) begin
                        prev     <= q_in;
                        good_cnt <= '0;
                        state    <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (en) begin
                        prev <= q_in;
                        if (step_ok) begin
                            good_cnt <= good_cnt + GW'(1);
                            if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                rev_count <= '0;
                            end
                        end else if (onehot) begin
                            // Legal word but wrong position: restart the run from it.
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= '0;
                            state    <= EMPTY;
                        end
                    end
                end
                LOCKED: begin
                    if (en) begin
                        if (step_ok) begin
                            prev <= q_in;
                            // Bit 0 set means the token just wrapped from the MSB.
                            if (q_in[0]) begin
                                rev_tick  <= 1'b1;
                                rev_count <= rev_count + REV_W'(1);
                            end
                        end else begin
                            state  <= FAULT;
                            locked <= 1'b0;
                            error  <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                        end
                    end
                end
                FAULT: begin
                    // Samples are ignored until the fault is acknowledged.
                    if (clr_err) begin
                        state    <= EMPTY;
                        error    <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: drives two ring_monitor instances (default widths and narrow
// counters) with identical directed + random stimulus and compares both against
// a position-based behavioural model of the monitor.
module tb_ring_monitor;
    localparam int W  = 4;
    localparam int LC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] q_in = '0;
    logic         en = 1'b0;
    logic         clr_err = 1'b0;

    logic         locked0, error0, tick0;
    logic [7:0]   rev0;
    logic [3:0]   err0;
    logic         locked1, error1, tick1;
    logic [1:0]   rev1;
    logic [1:0]   err1;

    int tests = 0;
    int fails = 0;

    // Model: phase 0=no reference, 1=acquiring, 2=locked, 3=fault.
    int phase = 0;
    int pos = 0;
    int run = 0;
    int revs = 0;
    int faults = 0;
    bit tick = 0;
    int cur = 0;

    always #5 clk = ~clk;

    ring_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .REV_W(8), .ERR_W(4)) dut0 (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .clr_err(clr_err),
        .locked(locked0), .error(error0), .rev_tick(tick0),
        .rev_count(rev0), .err_count(err0)
    );

    ring_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .REV_W(2), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .clr_err(clr_err),
        .locked(locked1), .error(error1), .rev_tick(tick1),
        .rev_count(rev1), .err_count(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [W-1:0] q);
        int k = 0;
        for (int i = 0; i < W; i++) if (q[i]) k = i;
        return k;
    endfunction

    task automatic model_step(input logic r, input logic [W-1:0] q, input logic e, input logic c);
        bit oh = ($countones(q) == 1);
        int k = idx_of(q);
        tick = 0;
        if (r) begin
            phase = 0; pos = 0; run = 0; revs = 0; faults = 0;
        end else begin
            case (phase)
                0: if (e && oh) begin pos = k; run = 0; phase = 1; end
                1: if (e) begin
                    if (!oh) begin
                        phase = 0; run = 0;
                    end else begin
                        if (k == (pos + 1) % W) begin
                            run++;
                            if (run == LC) begin phase = 2; revs = 0; end
                        end else run = 0;
                        pos = k;
                    end
                end
                2: if (e) begin
                    if (oh && k == (pos + 1) % W) begin
                        pos = k;
                        if (k == 0) begin tick = 1; revs++; end
                    end else begin
                        phase = 3; faults++;
                    end
                end
                default: if (c) begin phase = 0; run = 0; end
            endcase
        end
    endtask

    task automatic cyc(input logic r, input logic [W-1:0] q, input logic e, input logic c);
        @(negedge clk);
        rst = r; q_in = q; en = e; clr_err = c;
        @(posedge clk);
        model_step(r, q, e, c);
        #1;
        chk("locked0", locked0, phase == 2);
        chk("error0", error0, phase == 3);
        chk("tick0", tick0, tick);
        chk("rev0", rev0, revs % 256);
        chk("err0", err0, (faults > 15) ? 15 : faults);
        chk("locked1", locked1, phase == 2);
        chk("error1", error1, phase == 3);
        chk("tick1", tick1, tick);
        chk("rev1", rev1, revs % 4);
        chk("err1", err1, (faults > 3) ? 3 : faults);
        chk("excl", locked0 & error0, 1'b0);
        chk("tick_lock", tick0 & ~locked0, 1'b0);
    endtask

    task automatic put(input int k);
        logic [W-1:0] v;
        cur = k;
        v = '0;
        v[k] = 1'b1;
        cyc(1'b0, v, 1'b1, 1'b0);
    endtask

    task automatic spin(input int n);
        for (int i = 0; i < n; i++) put((cur + 1) % W);
    endtask

    initial begin
        logic [W-1:0] rq;
        // Reset
        cyc(1'b1, '0, 1'b0, 1'b0);
        cyc(1'b1, '0, 1'b1, 1'b0);

        // Stuck-at-zero ring never faults before lock
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Lock on 5th sample, then revolutions
        put(0); spin(4);
        spin(4);
        spin(4);

        // Fault, ignored samples, clear, relock
        cyc(1'b0, 4'b0011, 1'b1, 1'b0);
        spin(5);
        cyc(1'b0, '0, 1'b0, 1'b1);
        put(0); spin(4);

        // Skipped step during acquire: re-seed at 1000
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0);   // fault from locked
        cyc(1'b0, '0, 1'b0, 1'b1);        // clear
        put(0); put(1); put(3); put(0); put(1); put(2); put(3);
        // Clear and sample together in fault: sample discarded
        cyc(1'b0, 4'b1111, 1'b1, 1'b0);
        cyc(1'b0, 4'b0001, 1'b1, 1'b1);
        put(1); spin(4);

        // Enable gating with garbage on q_in
        for (int i = 0; i < 6; i++) cyc(1'b0, W'($urandom), 1'b0, 1'b0);
        spin(3);

        // Narrow counters: wrap revolutions and saturate faults
        spin(16);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0110, 1'b1, 1'b0);
            cyc(1'b0, '0, 1'b0, 1'b1);
            put(0); spin(4);
        end
        while (revs % 4 != 3) spin(1);
        cyc(1'b1, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            logic e, c, r;
            e = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) < 88) begin
                if (e) cur = (cur + 1) % W;
                rq = '0;
                rq[cur] = 1'b1;
            end else begin
                rq = W'($urandom);
                if ($countones(rq) == 1) cur = idx_of(rq);
            end
            cyc(r, rq, e, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
